execute_stage: RTL and testbench

Execute (EX) stage of the five-stage MIPS pipeline, sitting directly upstream of the memory-access stage and driving its EX/MEM inputs. It performs single-cycle ALU operations and compiles in a 32-iteration multiply/divide unit that stalls the front of the pipeline while it works. The EX/MEM pipeline register lives here: it captures on the falling clock edge and freezes under `stop_debug`.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/muldiv_iter.sv | 107 ++++++++++
 rtl/execute_stage.sv | 139 +++++++++++++
 tb/tb_execute_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- constants and types shared by the MIPS execute stage.
//   ALU operation codes (4-bit ALUOp field from decode)
//   Bubble values for the write-back / memory control bundles
//   Multiply/divide FSM state encoding and unit-select encoding
package mips_pkg;

    // ALU operation codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;
    localparam logic [3:0] OP_ZERO = 4'd15;

    // Control values carried by a pipeline bubble
    localparam logic [4:0] WB_BUBBLE  = 5'd0;
    localparam logic [2:0] MEM_BUBBLE = 3'd0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_sel_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic md_sel_e md_sel_of(input logic [3:0] op);
        case (op)
            OP_DIVU: return MD_DIVU;
            OP_REMU: return MD_REMU;
            default: return MD_MUL;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter -- iterative multiply / unsigned divide unit for the EX stage.
// Built only when EXECUTE_STAGE_MULDIV_EN is defined.
//
// Ports:
//   clk     in   pipeline clock, state updates on the falling edge
//   rst     in   asynchronous active-low reset (aborts any operation)
//   hold    in   freeze all state (debug stop)
//   start   in   begin an operation; only sampled in IDLE
//   sel     in   MUL / DIVU / REMU
//   a, b    in   operand A, operand B
//   busy    out  iterating
//   done    out  result valid for exactly one edge
//   result  out  low product, quotient or remainder
`ifdef EXECUTE_STAGE_MULDIV_EN
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             start,
    input  md_sel_e          sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    md_state_e        state;
    md_sel_e          sel_q;
    logic [CW-1:0]    cnt;
    // Register sharing between the two algorithms:
    //   acc : product accumulator (MUL) / partial remainder (DIV)
    //   opnd: shifting multiplicand (MUL) / divisor (DIV)
    //   shf : multiplier consumed LSB-first (MUL) /
    //         dividend consumed MSB-first, quotient shifted in (DIV)
    logic [WIDTH-1:0] acc, opnd, shf;
    logic [WIDTH-1:0] acc_nx, opnd_nx, shf_nx;
    logic [WIDTH:0]   trial;
    logic             ge;

    always_comb begin
        acc_nx  = acc;
        opnd_nx = opnd;
        shf_nx  = shf;
        trial   = {acc, shf[WIDTH-1]};
        ge      = 1'b0;
        if (sel_q == MD_MUL) begin
            if (shf[0])
                acc_nx = acc + opnd;
            opnd_nx = opnd << 1;
            shf_nx  = shf >> 1;
        end else begin
            // Restoring step. A zero divisor always "fits", which yields an
            // all-ones quotient and leaves the dividend as the remainder.
            ge     = trial >= {1'b0, opnd};
            acc_nx = ge ? (trial[WIDTH-1:0] - opnd) : trial[WIDTH-1:0];
            shf_nx = {shf[WIDTH-2:0], ge};
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            sel_q <= MD_MUL;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            shf   <= '0;
        end else if (!hold) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= MD_BUSY;
                        sel_q <= sel;
                        cnt   <= '0;
                        acc   <= '0;
                        opnd  <= b;
                        shf   <= a;
                    end
                end
                MD_BUSY: begin
                    acc  <= acc_nx;
                    opnd <= opnd_nx;
                    shf  <= shf_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= MD_DONE;
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy   = (state == MD_BUSY);
    assign done   = (state == MD_DONE);
    assign result = (sel_q == MD_DIVU) ? shf : acc;

endmodule
`endif

// File: rtl/execute_stage.sv
// execute_stage -- EX stage of the five-stage MIPS pipeline plus the EX/MEM
// pipeline register (falling-edge, async active-low reset, frozen by
// stop_debug).
//
// Optional feature macro: EXECUTE_STAGE_MULDIV_EN
//   defined   : MUL / DIVU / REMU run on the iterative muldiv_iter unit and
//               outStall holds the front of the pipeline while it works.
//   undefined : no iterative unit; those ops return 0 in one cycle and
//               outStall is tied low.
//
// Ports:
//   clk, rst, stop_debug              clock, async active-low reset, freeze
//   inValid                           ID/EX slot holds a real instruction
//   inWB, inMEM, inRegF_wreg          control / destination, passed through
//   inALUOp, inALUSrc, inShamt        operation, operand-B select, shift
//   inRegA, inRegB, inImm             operands
//   outWB, outMEM, outALUResult,
//   outALUZero, outRegB, outRegF_wreg EX/MEM register contents
//   outStall                          combinational hold request upstream
module execute_stage
    import mips_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULDIV_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_debug,
    input  logic             inValid,
    input  logic [4:0]       inWB,
    input  logic [2:0]       inMEM,
    input  logic [3:0]       inALUOp,
    input  logic             inALUSrc,
    input  logic [WIDTH-1:0] inRegA,
    input  logic [WIDTH-1:0] inRegB,
    input  logic [WIDTH-1:0] inImm,
    input  logic [4:0]       inShamt,
    input  logic [4:0]       inRegF_wreg,
    output logic [4:0]       outWB,
    output logic [2:0]       outMEM,
    output logic [WIDTH-1:0] outALUResult,
    output logic             outALUZero,
    output logic [WIDTH-1:0] outRegB,
    output logic [4:0]       outRegF_wreg,
    output logic             outStall
);

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] ex_res;
    logic             stall;

    assign op_b = inALUSrc ? inImm : inRegB;

    // Single-cycle ALU. Shifts act on operand B (the rt field in MIPS).
    always_comb begin
        alu_res = '0;
        case (inALUOp)
            OP_ADD:  alu_res = inRegA + op_b;
            OP_SUB:  alu_res = inRegA - op_b;
            OP_AND:  alu_res = inRegA & op_b;
            OP_OR:   alu_res = inRegA | op_b;
            OP_XOR:  alu_res = inRegA ^ op_b;
            OP_NOR:  alu_res = ~(inRegA | op_b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(inRegA) < $signed(op_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (inRegA < op_b)};
            OP_SLL:  alu_res = op_b << inShamt;
            OP_SRL:  alu_res = op_b >> inShamt;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> inShamt);
            OP_LUI:  alu_res = {op_b[15:0], {(WIDTH-16){1'b0}}};
            default: alu_res = '0;
        endcase
    end

`ifdef EXECUTE_STAGE_MULDIV_EN
    logic             md_start, md_busy, md_done;
    logic [WIDTH-1:0] md_result;
    md_sel_e          md_sel;

    assign md_start = inValid && is_muldiv(inALUOp);
    assign md_sel   = md_sel_of(inALUOp);

    muldiv_iter #(
        .WIDTH (WIDTH),
        .ITER  (MULDIV_ITER)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .hold   (stop_debug),
        .start  (md_start),
        .sel    (md_sel),
        .a      (inRegA),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // IDLE is "neither busy nor done": stall from presentation through the
    // last BUSY edge, release in DONE so the result registers on that edge.
    // Reset forces the stall low even if upstream still presents a mul/div.
    assign stall  = rst && (md_busy || (md_start && !md_done));
    assign ex_res = (md_done && is_muldiv(inALUOp)) ? md_result : alu_res;
`else
    assign stall  = 1'b0;
    assign ex_res = alu_res;
`endif

    assign outStall = stall;

    // EX/MEM register. A stalled or invalid slot becomes a bubble.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            outWB        <= WB_BUBBLE;
            outMEM       <= MEM_BUBBLE;
            outALUResult <= '0;
            outALUZero   <= 1'b1;
            outRegB      <= '0;
            outRegF_wreg <= '0;
        end else if (!stop_debug) begin
            if (stall || !inValid) begin
                outWB        <= WB_BUBBLE;
                outMEM       <= MEM_BUBBLE;
                outALUResult <= '0;
                outALUZero   <= 1'b1;
                outRegB      <= '0;
                outRegF_wreg <= '0;
            end else begin
                outWB        <= inWB;
                outMEM       <= inMEM;
                outALUResult <= ex_res;
                outALUZero   <= (ex_res == '0);
                outRegB      <= inRegB;
                outRegF_wreg <= inRegF_wreg;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage. One expected record is queued per
// falling clock edge by the stimulus; the monitor samples outStall mid-cycle
// (before the edge) and the EX/MEM outputs just after the edge, then pops
// and compares.
module tb_execute_stage;

    localparam int ITER = 32;

    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4, NOR_ = 4'd5, SLT = 4'd6,  SLTU = 4'd7;
    localparam logic [3:0] SLL = 4'd8,  SRL = 4'd9,  SRA = 4'd10, LUI = 4'd11;
    localparam logic [3:0] MUL = 4'd12, DIVU = 4'd13, REMU = 4'd14, ZOP = 4'd15;

    typedef struct packed {
        logic        stall;
        logic [4:0]  wb;
        logic [2:0]  mem;
        logic [31:0] res;
        logic        zero;
        logic [31:0] regb;
        logic [4:0]  wreg;
    } obs_t;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        stop_debug = 1'b0;
    logic        inValid = 1'b0;
    logic [4:0]  inWB = '0;
    logic [2:0]  inMEM = '0;
    logic [3:0]  inALUOp = '0;
    logic        inALUSrc = 1'b0;
    logic [31:0] inRegA = '0, inRegB = '0, inImm = '0;
    logic [4:0]  inShamt = '0;
    logic [4:0]  inRegF_wreg = '0;
    logic [4:0]  outWB;
    logic [2:0]  outMEM;
    logic [31:0] outALUResult;
    logic        outALUZero;
    logic [31:0] outRegB;
    logic [4:0]  outRegF_wreg;
    logic        outStall;

    obs_t exp_q[$];
    int   tag_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    execute_stage #(.WIDTH(32), .MULDIV_ITER(ITER)) dut (
        .clk          (clk),
        .rst          (rst),
        .stop_debug   (stop_debug),
        .inValid      (inValid),
        .inWB         (inWB),
        .inMEM        (inMEM),
        .inALUOp      (inALUOp),
        .inALUSrc     (inALUSrc),
        .inRegA       (inRegA),
        .inRegB       (inRegB),
        .inImm        (inImm),
        .inShamt      (inShamt),
        .inRegF_wreg  (inRegF_wreg),
        .outWB        (outWB),
        .outMEM       (outMEM),
        .outALUResult (outALUResult),
        .outALUZero   (outALUZero),
        .outRegB      (outRegB),
        .outRegF_wreg (outRegF_wreg),
        .outStall     (outStall)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic s, input logic [4:0] wb, input logic [2:0] mem,
                                input logic [31:0] r, input logic [31:0] rb, input logic [4:0] wr);
        obs_t o;
        o.stall = s; o.wb = wb; o.mem = mem; o.res = r;
        o.zero = (r == 32'h0); o.regb = rb; o.wreg = wr;
        return o;
    endfunction

    function automatic obs_t bubble(input logic s);
        return mk(s, 5'd0, 3'd0, 32'h0, 32'h0, 5'd0);
    endfunction

    function automatic obs_t cur_obs(input logic s);
        obs_t o;
        o.stall = s; o.wb = outWB; o.mem = outMEM; o.res = outALUResult;
        o.zero = outALUZero; o.regb = outRegB; o.wreg = outRegF_wreg;
        return o;
    endfunction

    task automatic compare(input int tag, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL tag=%0d got stall=%b wb=%h mem=%h res=%h zero=%b regb=%h wreg=%h | exp stall=%b wb=%h mem=%h res=%h zero=%b regb=%h wreg=%h",
                     tag, got.stall, got.wb, got.mem, got.res, got.zero, got.regb, got.wreg,
                     exp.stall, exp.wb, exp.mem, exp.res, exp.zero, exp.regb, exp.wreg);
        end
    endtask

    // Monitor: stall sampled before the edge, outputs after it.
    initial begin : monitor
        logic s;
        obs_t e;
        int   t;
        forever begin
            @(posedge clk);
            s = outStall;
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                compare(t, cur_obs(s), e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Called at negedge+1; queues the record for the next edge and waits it out.
    task automatic expect_edge(input int tag, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input int tag);
        inValid     = 1'b1;
        inALUOp     = op;
        inRegA      = a;
        inRegB      = b;
        inImm       = imm;
        inALUSrc    = src;
        inShamt     = 5'd4;
        inWB        = 5'(tag);
        inMEM       = 3'(tag + 1);
        inRegF_wreg = 5'(tag + 2);
    endtask

    task automatic alu(input int tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r);
        drive(op, a, b, 32'h0, 1'b0, tag);
        expect_edge(tag, mk(1'b0, inWB, inMEM, r, inRegB, inRegF_wreg));
    endtask

    task automatic reset_now(input int tag);
        #2;
        rst = 1'b0;
        inValid = 1'b0;
        #1;
        compare(tag, cur_obs(outStall), bubble(1'b0));
        expect_edge(tag, bubble(1'b0));
        rst = 1'b1;
    endtask

`ifdef EXECUTE_STAGE_MULDIV_EN
    // Stall for ITER+1 edges (plus any freeze), result on the following edge.
    task automatic md(input int tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input int frz_at, input int frz_len);
        drive(op, a, b, 32'h0, 1'b0, tag);
        for (int e = 0; e <= ITER; e++) begin
            if (e == frz_at) begin
                stop_debug = 1'b1;
                for (int f = 0; f < frz_len; f++)
                    expect_edge(tag, bubble(1'b1));
                stop_debug = 1'b0;
            end
            expect_edge(tag, bubble(1'b1));
        end
        expect_edge(tag, mk(1'b0, inWB, inMEM, r, inRegB, inRegF_wreg));
    endtask
`endif

    initial begin : stimulus
        obs_t held;
        @(negedge clk);
        #1;
        compare(1, cur_obs(outStall), bubble(1'b0));
        expect_edge(2, bubble(1'b0));
        rst = 1'b1;

        alu(3,  ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000);
        alu(4,  SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001);
        alu(5,  SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        alu(6,  SUB,  32'd5,        32'd5,        32'h00000000);
        alu(7,  SUB,  32'd3,        32'd5,        32'hFFFFFFFE);
        alu(8,  ADD,  32'hFFFFFFFF, 32'd2,        32'h00000001);
        alu(9,  AND_, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200);
        alu(10, OR_,  32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34);
        alu(11, XOR_, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34);
        alu(12, NOR_, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB);
        alu(13, SLL,  32'h80000001, 32'h80000001, 32'h00000010);
        alu(14, SRL,  32'h80000001, 32'h80000001, 32'h08000000);
        alu(15, SRA,  32'h80000001, 32'h80000001, 32'hF8000000);
        alu(16, ZOP,  32'h12345678, 32'h9ABCDEF0, 32'h00000000);

        // Immediate operand B; outRegB still carries inRegB
        drive(ADD, 32'd10, 32'd3, 32'hFFFFFFFE, 1'b1, 17);
        expect_edge(17, mk(1'b0, inWB, inMEM, 32'd8, 32'd3, inRegF_wreg));
        drive(LUI, 32'h12345678, 32'h00000055, 32'h0000ABCD, 1'b1, 18);
        expect_edge(18, mk(1'b0, inWB, inMEM, 32'hABCD0000, 32'h55, inRegF_wreg));

        // Invalid slot -> bubble
        drive(ADD, 32'd1, 32'd1, 32'h0, 1'b0, 19);
        inValid = 1'b0;
        expect_edge(19, bubble(1'b0));

        // Debug freeze holds the EX/MEM register
        alu(20, ADD, 32'd1, 32'd2, 32'd3);
        held = mk(1'b0, inWB, inMEM, 32'd3, 32'd2, inRegF_wreg);
        stop_debug = 1'b1;
        drive(ADD, 32'h10, 32'h20, 32'h0, 1'b0, 21);
        expect_edge(21, held);
        expect_edge(21, held);
        stop_debug = 1'b0;
        expect_edge(22, mk(1'b0, inWB, inMEM, 32'h30, 32'h20, inRegF_wreg));

`ifdef EXECUTE_STAGE_MULDIV_EN
        md(40, MUL,  32'h00012345, 32'h00010000, 32'h23450000, -1, 0);
        md(41, MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, -1, 0);
        md(42, DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, -1, 0);
        md(43, REMU, 32'd100,      32'd0,        32'd100,      -1, 0);
        md(44, DIVU, 32'd100,      32'd7,        32'd14,       11, 5);
        md(45, REMU, 32'd100,      32'd7,        32'd2,        -1, 0);
        md(46, DIVU, 32'hFFFFFFFF, 32'd3,        32'h55555555, -1, 0);
        alu(47, ADD, 32'd4, 32'd5, 32'd9);

        // Reset at the 10th BUSY edge aborts the multiply
        drive(MUL, 32'd3, 32'd5, 32'h0, 1'b0, 50);
        for (int e = 0; e <= 10; e++)
            expect_edge(50, bubble(1'b1));
        reset_now(51);
        alu(52, ADD, 32'd2, 32'd3, 32'd5);
        md(53, MUL, 32'd6, 32'd7, 32'd42, -1, 0);
`else
        // Without the iterative unit these ops finish at once with result 0
        alu(40, MUL,  32'h00012345, 32'h00010000, 32'h0);
        alu(41, DIVU, 32'd100,      32'd7,        32'h0);
        alu(42, REMU, 32'd100,      32'd7,        32'h0);
        reset_now(51);
        alu(52, ADD, 32'd2, 32'd3, 32'd5);
`endif

        inValid = 1'b0;
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
